opal_rx_deframer: RTL and testbench
===================================

// Module: opal_rx_deframer
// PURPOSE
//   Front end of the OPAL receive path. Brings the OPAL parallel link (data + enable + link clock)
//   into the clk domain and detects link-clock edges. Assembles one enable-framed burst into
//   NUM_VARS words and commits them atomically to registered outputs, then pulses o_ready.
//   Feeds the AXI register bank that exposes from_var1..from_varN to software.
// PARAMETERS
//   WORD_WIDTH   16     width of one link word / one output variable
//   NUM_VARS     16     data words per frame
//   TIMEOUT_CYC  4096   clk cycles with no link-clock edge before CAPTURE aborts
//   SYNC_STAGES  2      synchronizer flops per input bit (>=2)
// PORTS
//   clk          in   1                    system clock (100 MHz)
//   rst_n        in   1                    asynchronous active-low reset
//   i_data_rx    in   WORD_WIDTH+2         [W+1]=link clock, [W]=enable, [W-1:0]=data word
//   o_vars       out  WORD_WIDTH*NUM_VARS  committed frame; word k at [k*W +: W]
//   o_ready      out  1                    1-cycle pulse when o_vars updated
//   o_frame_err  out  1                    1-cycle pulse on short frame, timeout or checksum fail
//   o_frame_cnt  out  16                   committed-frame counter, wraps 0xFFFF->0
//   state_watch  out  4                    current FSM state encoding (debug)
// BEHAVIOUR
//   - Reset: o_vars=0, o_ready=0, o_frame_err=0, o_frame_cnt=0, state=IDLE (state_watch=0).
//   - All W+2 input bits pass through SYNC_STAGES flops, then one extra "prev" stage. A link edge
//     (lk_rise) is sync_clk=1 and prev_clk=0. Data/enable are taken from the same sync stage, so
//     alignment is preserved. Link clock must be <= clk/4; faster links are unsupported.
//   - FSM states / state_watch: IDLE=0, CAPTURE=1, COMMIT=2, WAIT_LOW=3.
//     IDLE:     en_sync rising (prev 0, now 1) -> CAPTURE, idx=0, timeout counter cleared.
//               An enable already high out of reset is ignored until it goes low, then high.
//     CAPTURE:  each lk_rise with en_sync=1 -> shadow[idx]=data, idx++.
//               idx reaches FRAME_LEN -> COMMIT.
//               en_sync falls before FRAME_LEN -> o_frame_err pulse, IDLE, shadow discarded.
//               No lk_rise for TIMEOUT_CYC cycles -> o_frame_err pulse, WAIT_LOW.
//     COMMIT:   one cycle: o_vars<=shadow, o_ready=1, o_frame_cnt++; -> WAIT_LOW.
//     WAIT_LOW: extra lk_rise while en high are ignored (overrun is not an error);
//               en_sync low -> IDLE.
//   - FRAME_LEN = NUM_VARS (or NUM_VARS+1, see CONFIGURATION).
//   - Latency: last word's raw link edge to o_ready = SYNC_STAGES+3 clk cycles.
//   - o_vars is stable between o_ready pulses. It is never partially updated; error frames
//     leave it unchanged.
//   - lk_rise coinciding with en_sync fall: the fall wins and the word is not captured.
//   - o_ready and o_frame_err are mutually exclusive in any cycle.
//   - rst_n asserted mid-frame: immediate return to reset values; shadow contents are discarded.
// CONFIGURATION
//   OPAL_RX_CHECKSUM_EN defined:
//     FRAME_LEN = NUM_VARS+1. The final word is a checksum equal to the sum mod 2^W of the
//     NUM_VARS data words. COMMIT occurs only on a match; a mismatch gives an o_frame_err pulse
//     with no o_vars/o_frame_cnt update -> WAIT_LOW.
//   OPAL_RX_CHECKSUM_EN undefined:
//     FRAME_LEN = NUM_VARS; no integrity check; no checksum logic is synthesized.
// TESTING
//   1 Reset, 16-word frame 0x0001..0x0010, link clk=clk/8
//     -> o_ready pulse once; o_vars[15:0]=0x0001, o_vars[255:240]=0x0010; o_frame_cnt=1.
//   2 Enable drops after 9 words
//     -> o_frame_err pulse, no o_ready, o_vars keeps previous frame, state_watch returns 0.
//   3 Enable held high, link clk stops after word 5, TIMEOUT_CYC=64
//     -> o_frame_err pulse 64 cycles after the last edge, state 3; then enable low -> state 0.
//   4 20 link edges in one enable window
//     -> words 0..15 committed, edges 16..19 ignored, single o_ready, no error.
//   5 CHECKSUM_EN, all data 0xFFFF
//     -> checksum 0xFFF0 commits; checksum 0xFFF1 -> o_frame_err, o_frame_cnt unchanged.
//   6 rst_n low at word 8, then release and send a full frame
//     -> all outputs 0 during reset; the next frame commits cleanly with o_frame_cnt=1.

Source files
------------

// File: rtl/opal_rx_deframer.sv
// OPAL receive deframer: synchronizes the parallel link, assembles one enable-framed burst and
// commits it atomically to o_vars. Define OPAL_RX_CHECKSUM_EN to require a trailing sum word.
module opal_rx_deframer #(
    parameter int WORD_WIDTH  = 16,
    parameter int NUM_VARS    = 16,
    parameter int TIMEOUT_CYC = 4096,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [WORD_WIDTH+1:0]          i_data_rx,
    output logic [WORD_WIDTH*NUM_VARS-1:0] o_vars,
    output logic                           o_ready,
    output logic                           o_frame_err,
    output logic [15:0]                    o_frame_cnt,
    output logic [3:0]                     state_watch
);
    localparam int W = WORD_WIDTH;
`ifdef OPAL_RX_CHECKSUM_EN
    localparam int FRAME_LEN = NUM_VARS + 1;
`else
    localparam int FRAME_LEN = NUM_VARS;
`endif
    localparam int IDXW = $clog2(FRAME_LEN + 1);
    localparam int CNTW = $clog2(TIMEOUT_CYC + 1);
    // Enable bit resets high so an enable already asserted out of reset never looks like a rise.
    localparam logic [W+1:0] SYNC_RST = {2'b01, {W{1'b0}}};

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CAPTURE  = 4'd1,
        COMMIT   = 4'd2,
        WAIT_LOW = 4'd3
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0][W+1:0] sync_q;
    logic [1:0]                    prev_ctl_q;
    logic [W+1:0]                  link_now;
    logic                          lk_rise;
    logic                          en_sync;
    logic                          en_rise;
    logic [W-1:0]                  data_sync;

    logic [IDXW-1:0] idx_q;
    logic [CNTW-1:0] to_cnt_q;
    logic [W-1:0]    shadow_q [FRAME_LEN];
    logic [W-1:0]    vars_q   [NUM_VARS];
    logic [15:0]     frame_cnt_q;
    logic            ready_q;
    logic            err_q;

    logic idx_full;
    logic timeout_hit;
    logic frame_ok;
    logic start_frame;
    logic do_capture;
    logic err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= {SYNC_STAGES{SYNC_RST}};
            prev_ctl_q <= SYNC_RST[W+1:W];
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], i_data_rx};
            prev_ctl_q <= sync_q[SYNC_STAGES-1][W+1:W];
        end
    end

    assign link_now  = sync_q[SYNC_STAGES-1];
    assign data_sync = link_now[W-1:0];
    assign en_sync   = link_now[W];
    assign lk_rise   = link_now[W+1] & ~prev_ctl_q[1];
    assign en_rise   = en_sync & ~prev_ctl_q[0];

    assign idx_full    = (idx_q == IDXW'(FRAME_LEN));
    assign timeout_hit = !lk_rise && (to_cnt_q == CNTW'(TIMEOUT_CYC - 1));

`ifdef OPAL_RX_CHECKSUM_EN
    logic [W-1:0] sum_c;
    always_comb begin
        sum_c = '0;
        for (int k = 0; k < NUM_VARS; k++) begin
            sum_c = sum_c + shadow_q[k];
        end
    end
    assign frame_ok = (sum_c == shadow_q[NUM_VARS]);
`else
    assign frame_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A completed frame outranks a same-cycle enable fall; the fall outranks a captured edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (en_rise) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (idx_full)         state_d = frame_ok ? COMMIT : WAIT_LOW;
                else if (!en_sync)    state_d = IDLE;
                else if (timeout_hit) state_d = WAIT_LOW;
            end
            COMMIT: begin
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!en_sync) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_frame = 1'b0;
        do_capture  = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                start_frame = en_rise;
            end
            CAPTURE: begin
                do_capture = !idx_full && en_sync && lk_rise;
                err_d      = idx_full ? !frame_ok : (!en_sync || timeout_hit);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            to_cnt_q    <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            for (int k = 0; k < NUM_VARS; k++) begin
                vars_q[k] <= '0;
            end
        end else begin
            ready_q <= (state_q == COMMIT);
            err_q   <= err_d;

            if (start_frame) begin
                idx_q <= '0;
            end else if (do_capture) begin
                idx_q <= idx_q + IDXW'(1);
            end

            if (start_frame || lk_rise) begin
                to_cnt_q <= '0;
            end else if (state_q == CAPTURE) begin
                to_cnt_q <= to_cnt_q + CNTW'(1);
            end

            if (state_q == COMMIT) begin
                for (int k = 0; k < NUM_VARS; k++) begin
                    vars_q[k] <= shadow_q[k];
                end
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    // Shadow needs no reset: idx restarts at 0 and every slot is rewritten before a commit.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FRAME_LEN; k++) begin
            if (do_capture && (idx_q == IDXW'(k))) begin
                shadow_q[k] <= data_sync;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VARS; gi++) begin : g_vars_out
            assign o_vars[gi*W +: W] = vars_q[gi];
        end
    endgenerate

    assign o_ready     = ready_q;
    assign o_frame_err = err_q;
    assign o_frame_cnt = frame_cnt_q;
    assign state_watch = state_q;

endmodule

// File: tb/tb_opal_rx_deframer.sv
// Self-checking bench for opal_rx_deframer: table-driven frames, hand-written corner sequences
// and randomized enable windows checked against a frame-level reference model.
module tb_opal_rx_deframer;
    localparam int W  = 16;
    localparam int NV = 16;
    localparam int TO = 64;
    localparam int SS = 2;
`ifdef OPAL_RX_CHECKSUM_EN
    localparam int FL   = NV + 1;
    localparam bit CSUM = 1'b1;
`else
    localparam int FL   = NV;
    localparam bit CSUM = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            lk = 1'b0;
    logic            en = 1'b0;
    logic [W-1:0]    dat = '0;
    logic [W+1:0]    i_data_rx;
    logic [W*NV-1:0] o_vars;
    logic            o_ready;
    logic            o_frame_err;
    logic [15:0]     o_frame_cnt;
    logic [3:0]      state_watch;

    assign i_data_rx = {lk, en, dat};

    opal_rx_deframer #(
        .WORD_WIDTH (W),
        .NUM_VARS   (NV),
        .TIMEOUT_CYC(TO),
        .SYNC_STAGES(SS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_data_rx  (i_data_rx),
        .o_vars     (o_vars),
        .o_ready    (o_ready),
        .o_frame_err(o_frame_err),
        .o_frame_cnt(o_frame_cnt),
        .state_watch(state_watch)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ready_cnt = 0;
    int err_cnt = 0;
    int ready_cyc = 0;
    int err_cyc = 0;
    int excl_viol = 0;
    int commit_edge_cyc = 0;

    logic [W*NV-1:0] exp_vars = '0;
    logic [15:0]     exp_cnt = '0;
    logic [W-1:0]    win_q[$];

    typedef struct {
        int nwords;
        int pat;       // 0: 1..n, 1: random, 2: all ones
        bit corrupt;   // checksum word off by one
        bit exp_ready;
        bit exp_err;
    } vec_t;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_ready) begin
            ready_cnt++;
            ready_cyc = cyc;
        end
        if (o_frame_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (o_ready && o_frame_err) excl_viol++;
    end

    task automatic check(input string name, input logic [W*NV-1:0] act, input logic [W*NV-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic waitn(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic link_edge(input logic [W-1:0] word, output int rise_cyc);
        lk  = 1'b0;
        dat = word;
        waitn(4);
        lk       = 1'b1;
        rise_cyc = cyc;
        waitn(4);
    endtask

    task automatic fill_words(input int n, input int pat);
        win_q.delete();
        for (int k = 0; k < n; k++) begin
            case (pat)
                0:       win_q.push_back(W'(k + 1));
                2:       win_q.push_back({W{1'b1}});
                default: win_q.push_back(W'($urandom));
            endcase
        end
    endtask

    // Sends win_q as one enable window (checksum inserted after the data words when enabled),
    // then compares the DUT against the frame-level expectation.
    task automatic run_window(input string tag, input bit corrupt, input bit exp_ready, input bit exp_err);
        int r0;
        int e0;
        int rc;
        logic [W-1:0] seq[$];
        logic [W-1:0] s;
        r0 = ready_cnt;
        e0 = err_cnt;
        s  = '0;
        for (int k = 0; k < win_q.size(); k++) begin
            seq.push_back(win_q[k]);
            if (k < NV) s = s + win_q[k];
            if (CSUM && k == NV - 1) seq.push_back(corrupt ? s + W'(1) : s);
        end
        en = 1'b1;
        waitn(6);
        for (int k = 0; k < seq.size(); k++) begin
            link_edge(seq[k], rc);
            if (k == FL - 1) commit_edge_cyc = rc;
        end
        waitn(8);
        en = 1'b0;
        waitn(8);
        if (exp_ready) begin
            for (int k = 0; k < NV; k++) exp_vars[k*W +: W] = win_q[k];
            exp_cnt = exp_cnt + 16'd1;
            check({tag, " latency"}, W*NV'(ready_cyc - commit_edge_cyc), W*NV'(SS + 3));
        end
        check({tag, " ready_pulses"}, W*NV'(ready_cnt - r0), W*NV'(exp_ready));
        check({tag, " err_pulses"}, W*NV'(err_cnt - e0), W*NV'(exp_err));
        check({tag, " vars"}, o_vars, exp_vars);
        check({tag, " frame_cnt"}, W*NV'(o_frame_cnt), W*NV'(exp_cnt));
        check({tag, " state"}, W*NV'(state_watch), W*NV'(0));
        $display("window %s: %0d words -> ready=%0d err=%0d cnt=%0d", tag, win_q.size(),
                 ready_cnt - r0, err_cnt - e0, o_frame_cnt);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " vars"}, o_vars, '0);
        check({tag, " ready"}, W*NV'(o_ready), '0);
        check({tag, " err"}, W*NV'(o_frame_err), '0);
        check({tag, " frame_cnt"}, W*NV'(o_frame_cnt), '0);
        check({tag, " state"}, W*NV'(state_watch), '0);
    endtask

    vec_t tbl[$];

    initial begin
        int rc;
        int r0;
        int e0;
        int t;
        int n;
        bit cor;
        bit rdy;
        logic [W*NV-1:0] held;

        tbl.push_back('{16, 0, 1'b0, 1'b1, 1'b0});  // incrementing frame
        tbl.push_back('{9,  1, 1'b0, 1'b0, 1'b1});  // short frame
        tbl.push_back('{20, 1, 1'b0, 1'b1, 1'b0});  // overrun ignored
        tbl.push_back('{0,  1, 1'b0, 1'b0, 1'b1});  // empty window
        tbl.push_back('{15, 1, 1'b0, 1'b0, 1'b1});  // one word short
        tbl.push_back('{16, 1, 1'b0, 1'b1, 1'b0});
`ifdef OPAL_RX_CHECKSUM_EN
        tbl.push_back('{16, 2, 1'b0, 1'b1, 1'b0});  // sum 0xFFF0 accepted
        tbl.push_back('{16, 2, 1'b1, 1'b0, 1'b1});  // sum 0xFFF1 rejected
`endif

        // Reset state
        waitn(4);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        waitn(8);

        // Table-driven frames
        for (int i = 0; i < tbl.size(); i++) begin
            fill_words(tbl[i].nwords, tbl[i].pat);
            run_window($sformatf("tbl%0d", i), tbl[i].corrupt, tbl[i].exp_ready, tbl[i].exp_err);
            if (i == 0) begin
                check("tbl0 word0", W*NV'(o_vars[15:0]), W*NV'(16'h0001));
                check("tbl0 word15", W*NV'(o_vars[255:240]), W*NV'(16'h0010));
            end
        end

        // Timeout: link clock stops after word 5 while enable stays high
        r0   = ready_cnt;
        e0   = err_cnt;
        held = o_vars;
        en   = 1'b1;
        waitn(6);
        for (int k = 0; k < 5; k++) link_edge(W'($urandom), rc);
        t = 0;
        while (err_cnt == e0 && t < 300) begin
            waitn(1);
            t++;
        end
        check("timeout err_pulse", W*NV'(err_cnt - e0), W*NV'(1));
        // last raw edge -> synchronizer stages -> one capture edge -> TO idle cycles
        check("timeout delay", W*NV'(err_cyc - rc), W*NV'(TO + SS + 1));
        waitn(4);
        check("timeout state", W*NV'(state_watch), W*NV'(3));
        en = 1'b0;
        waitn(8);
        check("timeout idle", W*NV'(state_watch), W*NV'(0));
        check("timeout ready", W*NV'(ready_cnt - r0), W*NV'(0));
        check("timeout vars", o_vars, held);
        $display("timeout sequence: err after %0d cycles", err_cyc - rc);

        // Reset mid-frame, enable held high across release
        en = 1'b1;
        waitn(6);
        for (int k = 0; k < 8; k++) link_edge(W'(k + 16'h0100), rc);
        rst_n = 1'b0;
        waitn(3);
        check_reset_outputs("midreset");
        exp_vars = '0;
        exp_cnt  = '0;
        waitn(2);
        rst_n = 1'b1;
        e0    = err_cnt;
        waitn(20);
        check("stale_en state", W*NV'(state_watch), W*NV'(0));
        check("stale_en err", W*NV'(err_cnt - e0), W*NV'(0));
        en = 1'b0;
        waitn(8);
        fill_words(16, 1);
        run_window("post_reset", 1'b0, 1'b1, 1'b0);
        check("post_reset cnt1", W*NV'(o_frame_cnt), W*NV'(1));

        // Randomized windows against the frame-level model
        for (int i = 0; i < 8; i++) begin
            n   = $urandom_range(0, 22);
            cor = CSUM ? bit'($urandom_range(0, 1)) : 1'b0;
            rdy = (n >= NV) && !cor;
            fill_words(n, 1);
            run_window($sformatf("rand%0d", i), cor, rdy, !rdy);
        end

        check("ready_err_exclusive", W*NV'(excl_viol), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
